// File: rtl/green_ins_encoder.sv
// ---------------------------------------------------------------------------
// green_ins_encoder
//
// Instruction encoder/issuer for the green circuit. Abstract commands
// (LD/ST/INC/BR, register select, 11-bit immediate) are accepted over a
// valid/ready handshake. Each one is packed into a 16-bit instruction word
// and buffered in a small show-ahead FIFO. The head of the FIFO is issued to
// the green decoder.
//
// After a BR is consumed downstream, the issuer stalls for BR_SHADOW cycles.
// If br_taken is seen during that shadow, every queued word is flushed.
//
// Word format: ins[15:12] = {2'b00, op}, ins[11] = rsel, ins[10:0] = imm.
// Whenever ins_valid is low, ins carries the NOP word 16'hF000.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, 2..16)
//   BR_SHADOW  stall cycles after a BR issues (1..15)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   command accepted when cmd_valid && cmd_ready
//   cmd_op      0=LD 1=ST 2=INC 3=BR
//   cmd_rsel    0=register A, 1=register B
//   cmd_imm     immediate / branch offset
//   ins         encoded instruction word (head of FIFO, or NOP)
//   ins_valid   ins holds a real instruction
//   ins_ready   downstream consumes ins when ins_valid && ins_ready
//   br_taken    branch resolution, only looked at in BR_WAIT
//   busy        FIFO non-empty or not in RUN
//   issued_cnt  (GREEN_ENC_STATS_EN only) saturating count of issued words
//   flush_cnt   (GREEN_ENC_STATS_EN only) saturating count of flush cycles
//
// Optional feature macro: GREEN_ENC_STATS_EN. This macro adds the
// statistics outputs and the counters behind them.
//
// States:
//   RUN     | normal issue; head of FIFO is presented on ins
//   BR_WAIT | branch shadow; issue stalled, shadow counter running
// ---------------------------------------------------------------------------
module green_ins_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BR_SHADOW = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_rsel,
  input  logic [10:0] cmd_imm,
  output logic [15:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        br_taken,
`ifdef GREEN_ENC_STATS_EN
  output logic [15:0] issued_cnt,
  output logic [7:0]  flush_cnt,
`endif
  output logic        busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] NOP_WORD = 16'hF000;
  localparam logic [3:0]  BR_OPC   = 4'b0011;

  typedef enum logic {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [3:0]    shadow_cnt;

  logic          empty;
  logic          full;
  logic          flush;
  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic [15:0]   new_word;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign flush    = (state == BR_WAIT) && br_taken;
  assign head     = mem[rd_ptr];
  assign new_word = {2'b00, cmd_op, cmd_rsel, cmd_imm};

  // A pop in the same cycle never frees space for a push: cmd_ready looks
  // only at the registered fill level.
  assign cmd_ready = !full && !flush;
  assign ins_valid = !empty && (state == RUN);
  assign ins       = ins_valid ? head : NOP_WORD;
  assign busy      = !empty || (state != RUN);

  assign push = cmd_valid && cmd_ready;
  assign pop  = ins_valid && ins_ready;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= RUN;
      shadow_cnt <= '0;
    end else if (flush) begin
      // A taken branch discards everything queued behind it.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= RUN;
      shadow_cnt <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        RUN: begin
          if (pop && (head[15:12] == BR_OPC)) begin
            state      <= BR_WAIT;
            shadow_cnt <= 4'(BR_SHADOW);
          end
        end
        BR_WAIT: begin
          // Counting "<= 1" also guards against a zero load.
          if (shadow_cnt <= 4'd1) begin
            state      <= RUN;
            shadow_cnt <= '0;
          end else begin
            shadow_cnt <= shadow_cnt - 4'd1;
          end
        end
        default: begin
          state      <= RUN;
          shadow_cnt <= '0;
        end
      endcase
    end
  end

`ifdef GREEN_ENC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (pop && (issued_cnt != 16'hFFFF)) begin
        issued_cnt <= issued_cnt + 16'd1;
      end
      if (flush && (flush_cnt != 8'hFF)) begin
        flush_cnt <= flush_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_green_ins_encoder.sv
module tb_green_ins_encoder;

  localparam int DEPTH     = 4;
  localparam int BR_SHADOW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_rsel;
  logic [10:0] cmd_imm;
  logic [15:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        br_taken;
  logic        busy;
`ifdef GREEN_ENC_STATS_EN
  logic [15:0] issued_cnt;
  logic [7:0]  flush_cnt;
`endif

  green_ins_encoder #(.DEPTH(DEPTH), .BR_SHADOW(BR_SHADOW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rsel   (cmd_rsel),
    .cmd_imm    (cmd_imm),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .br_taken   (br_taken),
`ifdef GREEN_ENC_STATS_EN
    .issued_cnt (issued_cnt),
    .flush_cnt  (flush_cnt),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of words, plus the number of stall cycles left.
  logic [15:0] q[$];
  int          stall_left = 0;
  int          m_issued   = 0;
  int          m_flushes  = 0;

  // Values sampled in the most recent step (used for the directed spot checks).
  logic [15:0] obs_ins;
  logic        obs_valid;
  logic        obs_ready;
  logic        obs_busy;

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    q.delete();
    stall_left = 0;
    m_issued   = 0;
    m_flushes  = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then
  // advance the model by the handshakes that happen at the rising edge.
  task automatic step(input logic cv, input logic [1:0] op, input logic rs,
                      input logic [10:0] im, input logic ir, input logic bt);
    logic [15:0] e_ins;
    logic        e_valid, e_ready, e_busy, e_flush;
    logic [15:0] w;
    @(negedge clk);
    cmd_valid = cv;
    cmd_op    = op;
    cmd_rsel  = rs;
    cmd_imm   = im;
    ins_ready = ir;
    br_taken  = bt;
    #1;
    e_flush = (stall_left > 0) && bt;
    e_valid = (q.size() > 0) && (stall_left == 0);
    e_ins   = e_valid ? q[0] : 16'hF000;
    e_ready = (q.size() < DEPTH) && !e_flush;
    e_busy  = (q.size() > 0) || (stall_left > 0);
    obs_ins   = ins;
    obs_valid = ins_valid;
    obs_ready = cmd_ready;
    obs_busy  = busy;
    chk("ins",       16'(ins),       e_ins);
    chk("ins_valid", 16'(ins_valid), 16'(e_valid));
    chk("cmd_ready", 16'(cmd_ready), 16'(e_ready));
    chk("busy",      16'(busy),      16'(e_busy));
`ifdef GREEN_ENC_STATS_EN
    chk("issued_cnt", issued_cnt,      16'(m_issued));
    chk("flush_cnt",  16'(flush_cnt),  16'(m_flushes));
`endif
    @(posedge clk);
    if (e_flush) begin
      q.delete();
      stall_left = 0;
      if (m_flushes < 255) m_flushes++;
    end else if (stall_left > 0) begin
      stall_left--;
    end
    if (e_valid && ir) begin
      w = q.pop_front();
      if (m_issued < 65535) m_issued++;
      if (w[15:12] == 4'd3) stall_left = BR_SHADOW;
    end
    if (cv && e_ready) q.push_back({2'b00, op, rs, im});
  endtask

  task automatic idle(input logic ir);
    step(1'b0, 2'd0, 1'b0, 11'd0, ir, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_rsel = 1'b0;
    cmd_imm = 11'd0; ins_ready = 1'b0; br_taken = 1'b0;
    model_reset();
    #1;
    chk("rst_ins",       16'(ins),       16'hF000);
    chk("rst_ins_valid", 16'(ins_valid), 16'd0);
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("rst_busy",      16'(busy),      16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LD B 0x005 appears the next cycle and is consumed.
    step(1'b1, 2'd0, 1'b1, 11'h005, 1'b1, 1'b0);
    idle(1'b1);
    chk("ld_word", obs_ins, 16'h0805);
    chk("ld_valid", 16'(obs_valid), 16'd1);
    idle(1'b1);
    chk("ld_drained_busy", 16'(obs_busy), 16'd0);

    // Fill the FIFO with ins_ready low; a 5th command waits for a pop.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 1'b0, 11'(i), 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b1, 11'h055, 1'b0, 1'b0);
    chk("full_ready", 16'(obs_ready), 16'd0);
    step(1'b1, 2'd2, 1'b1, 11'h055, 1'b1, 1'b0);
    chk("full_pop_ready", 16'(obs_ready), 16'd0);
    step(1'b1, 2'd2, 1'b1, 11'h055, 1'b0, 1'b0);
    chk("after_pop_ready", 16'(obs_ready), 16'd1);
    repeat (6) idle(1'b1);

    // INC A 0 then ST B 0x7FF, back to back.
    step(1'b1, 2'd2, 1'b0, 11'h000, 1'b1, 1'b0);
    step(1'b1, 2'd1, 1'b1, 11'h7FF, 1'b1, 1'b0);
    chk("inc_word", obs_ins, 16'h2000);
    idle(1'b1);
    chk("st_word", obs_ins, 16'h1FFF);
    idle(1'b1);

    // BR not taken: two stall cycles, then the LD issues.
    step(1'b1, 2'd3, 1'b0, 11'h010, 1'b1, 1'b0);
    step(1'b1, 2'd0, 1'b0, 11'h001, 1'b1, 1'b0);
    chk("br_word", obs_ins, 16'h3010);
    idle(1'b1);
    chk("shadow1_ins", obs_ins, 16'hF000);
    chk("shadow1_valid", 16'(obs_valid), 16'd0);
    idle(1'b1);
    chk("shadow2_valid", 16'(obs_valid), 16'd0);
    idle(1'b1);
    chk("post_br_word", obs_ins, 16'h0001);
    idle(1'b1);

    // BR taken in the first shadow cycle: the LD is flushed.
    step(1'b1, 2'd3, 1'b0, 11'h010, 1'b1, 1'b0);
    step(1'b1, 2'd0, 1'b0, 11'h001, 1'b1, 1'b0);
    step(1'b0, 2'd0, 1'b0, 11'h000, 1'b1, 1'b1);
    chk("flush_ready", 16'(obs_ready), 16'd0);
    idle(1'b1);
    chk("flushed_valid", 16'(obs_valid), 16'd0);
    chk("flushed_busy", 16'(obs_busy), 16'd0);

    // Reset while in BR_WAIT with 3 entries queued.
    step(1'b1, 2'd3, 1'b1, 11'h123, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 1'b0, 11'(i + 8), 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 11'd0, 1'b1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0; ins_ready = 1'b0; br_taken = 1'b0;
    #1;
    chk("pre_rst_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ins",       16'(ins),       16'hF000);
    chk("mid_rst_ins_valid", 16'(ins_valid), 16'd0);
    chk("mid_rst_cmd_ready", 16'(cmd_ready), 16'd1);
    chk("mid_rst_busy",      16'(busy),      16'd0);
`ifdef GREEN_ENC_STATS_EN
    chk("mid_rst_issued", issued_cnt,     16'd0);
    chk("mid_rst_flush",  16'(flush_cnt), 16'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)), 1'($urandom),
           11'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0));
    end
    repeat (12) idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
